// File: rtl/ram_result_reader_if.sv
// Character stream from the RAM readback engine to the display/UART sink.
interface ram_result_reader_if;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] char_index;

    // Source side: the readback engine
    modport master (
        output char_data,
        output char_valid,
        output char_index,
        input  char_ready
    );

    // Sink side: display or UART
    modport slave (
        input  char_data,
        input  char_valid,
        input  char_index,
        output char_ready
    );
endinterface

// File: rtl/ram_result_reader.sv
// Walks BUF_LEN bytes of the character buffer in data RAM over the idle-mode
// read port and presents each byte on a valid/ready stream.
module ram_result_reader #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned BASE_ADDR   = 1500,
    parameter int unsigned BUF_LEN     = 108,
    parameter int unsigned RD_LAT      = 1,
    parameter bit          STOP_ON_NUL = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    output logic [ADDR_W-1:0]   read_addr,
    input  logic [31:0]         read_data,
    ram_result_reader_if.master char_stream,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [7:0]        IdxLast  = 8'(BUF_LEN - 1);
    localparam logic [1:0]        LatLast  = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StPresent,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic [1:0]        lat_q, lat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        index_q, index_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [7:0]        rd_byte;
    logic [7:0]        idx_next;
    logic              unused_read_data;

    assign rd_byte          = read_data[7:0];
    assign idx_next         = idx_q + 8'd1;
    assign unused_read_data = ^read_data[31:8];

    // Next-state and registered-output computation; abort overrides everything
    // but reset, and leaves no partial state behind.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        data_d  = data_q;
        index_d = index_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = StIdle;
            idx_d   = 8'd0;
            lat_d   = 2'd0;
            addr_d  = BaseAddr;
            data_d  = 8'd0;
            index_d = 8'd0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    addr_d = BaseAddr;
                    idx_d  = 8'd0;
                    if (start) begin
                        state_d = StIssue;
                    end
                end
                StIssue: begin
                    // Address is already on the port; the RAM samples it this edge
                    addr_d  = BaseAddr + ADDR_W'(idx_q);
                    lat_d   = 2'd0;
                    state_d = StWait;
                end
                StWait: begin
                    if (lat_q == LatLast) begin
                        data_d  = rd_byte;
                        index_d = idx_q;
                        if (STOP_ON_NUL && (rd_byte == 8'h00)) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            state_d = StPresent;
                        end
                    end else begin
                        lat_d = lat_q + 2'd1;
                    end
                end
                StPresent: begin
                    if (valid_q && char_stream.char_ready) begin
                        valid_d = 1'b0;
                        if (idx_q == IdxLast) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            // Next address goes out now so it is stable for ISSUE
                            idx_d   = idx_next;
                            addr_d  = BaseAddr + ADDR_W'(idx_next);
                            state_d = StIssue;
                        end
                    end
                end
                StDone: begin
                    addr_d  = BaseAddr;
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= 8'd0;
            lat_q   <= 2'd0;
            addr_q  <= BaseAddr;
            data_q  <= 8'd0;
            index_q <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign read_addr              = addr_q;
    assign char_stream.char_data  = data_q;
    assign char_stream.char_valid = valid_q;
    assign char_stream.char_index = index_q;
    assign busy                   = busy_q;
    assign done                   = done_q;

endmodule

// File: tb/tb_ram_result_reader.sv
// Directed bench for ram_result_reader: three instances cover the default
// configuration, NUL-terminated readback and a 3-cycle RAM with a 1-byte buffer.
module tb_ram_result_reader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mem [4096];

    // Instance A: defaults
    logic        start_a, abort_a, busy_a, done_a;
    logic [11:0] addr_a;
    logic [31:0] rdata_a;
    ram_result_reader_if if_a ();

    // Instance B: STOP_ON_NUL
    logic        start_b, abort_b, busy_b, done_b;
    logic [11:0] addr_b;
    logic [31:0] rdata_b;
    ram_result_reader_if if_b ();

    // Instance C: RD_LAT=3, BUF_LEN=1
    logic        start_c, abort_c, busy_c, done_c;
    logic [11:0] addr_c;
    logic [31:0] rdata_c;
    logic [31:0] pipe_c [3];
    ram_result_reader_if if_c ();

    ram_result_reader #(.ADDR_W(12), .BASE_ADDR(1500), .BUF_LEN(108), .RD_LAT(1),
                        .STOP_ON_NUL(1'b0)) u_dut_a (
        .clock(clock), .reset(reset), .start(start_a), .abort(abort_a),
        .read_addr(addr_a), .read_data(rdata_a), .char_stream(if_a),
        .busy(busy_a), .done(done_a));

    ram_result_reader #(.ADDR_W(12), .BASE_ADDR(1500), .BUF_LEN(108), .RD_LAT(1),
                        .STOP_ON_NUL(1'b1)) u_dut_b (
        .clock(clock), .reset(reset), .start(start_b), .abort(abort_b),
        .read_addr(addr_b), .read_data(rdata_b), .char_stream(if_b),
        .busy(busy_b), .done(done_b));

    ram_result_reader #(.ADDR_W(12), .BASE_ADDR(1500), .BUF_LEN(1), .RD_LAT(3),
                        .STOP_ON_NUL(1'b0)) u_dut_c (
        .clock(clock), .reset(reset), .start(start_c), .abort(abort_c),
        .read_addr(addr_c), .read_data(rdata_c), .char_stream(if_c),
        .busy(busy_c), .done(done_c));

    // RAM read ports: address sampled at an edge, data usable RD_LAT edges later
    always @(posedge clock) begin
        rdata_a   <= mem[addr_a];
        rdata_b   <= mem[addr_b];
        pipe_c[0] <= mem[addr_c];
        pipe_c[1] <= pipe_c[0];
        pipe_c[2] <= pipe_c[1];
    end
    assign rdata_c = pipe_c[2];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic init_mem;
        for (int i = 0; i < 108; i++) begin
            mem[1500 + i] = {24'hABCDEF, 8'(8'h41 + i)};
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        total++;
        if (addr_a !== 12'd1500 || if_a.char_data !== 8'h00 || if_a.char_valid !== 1'b0 ||
            if_a.char_index !== 8'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_a: addr=%0d data=%h valid=%b idx=%0d busy=%b done=%b, want 1500 00 0 0 0 0",
                     addr_a, if_a.char_data, if_a.char_valid, if_a.char_index, busy_a, done_a);
        end
        reset = 1'b0;
        tick;
        total++;
        if (addr_c !== 12'd1500 || busy_c !== 1'b0 || if_c.char_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_c: addr=%0d busy=%b valid=%b, want 1500 0 0",
                     addr_c, busy_c, if_c.char_valid);
        end
    endtask

    // T1 plus ignored start pulses mid-run and during DONE
    task automatic test_stream;
        int n, last_cyc, exp_cyc, done_cnt, done_cyc;
        init_mem();
        if_a.char_ready = 1'b1;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        n = 0; last_cyc = 0; done_cnt = 0; done_cyc = 0;
        for (int cyc = 1; cyc <= 340; cyc++) begin
            tick;
            if (if_a.char_valid) begin
                total++;
                if (if_a.char_data !== 8'(8'h41 + n) || if_a.char_index !== 8'(n)) begin
                    bad++;
                    $display("FAIL t1_byte n=%0d: data=%h idx=%0d, want data=%h idx=%0d",
                             n, if_a.char_data, if_a.char_index, 8'(8'h41 + n), n);
                end
                exp_cyc = (n == 0) ? 2 : last_cyc + 3;
                total++;
                if (cyc !== exp_cyc) begin
                    bad++;
                    $display("FAIL t1_timing n=%0d: valid at cycle %0d, want %0d", n, cyc, exp_cyc);
                end
                last_cyc = cyc;
                n++;
            end
            if (done_a) begin
                done_cnt++;
                done_cyc = cyc;
            end
            start_a = done_a || (cyc == 100);
        end
        start_a = 1'b0;
        total++;
        if (n !== 108 || done_cnt !== 1 || done_cyc !== 324 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL t1_end: bytes=%0d dones=%0d done_cyc=%0d busy=%b, want 108 1 324 0",
                     n, done_cnt, done_cyc, busy_a);
        end
    endtask

    // T2: random back-pressure
    task automatic test_backpressure;
        int n;
        logic prev_valid, prev_ready, done_seen;
        logic [7:0] held_data, held_idx;
        start_a = 1'b1;
        if_a.char_ready = 1'b0;
        tick;
        start_a = 1'b0;
        n = 0; prev_valid = 1'b0; prev_ready = 1'b0; done_seen = 1'b0;
        held_data = 8'h00; held_idx = 8'h00;
        for (int cyc = 1; cyc <= 2000 && !done_seen; cyc++) begin
            tick;
            if (prev_valid && prev_ready) begin
                total++;
                if (held_data !== 8'(8'h41 + n) || held_idx !== 8'(n)) begin
                    bad++;
                    $display("FAIL t2_byte n=%0d: data=%h idx=%0d, want data=%h idx=%0d",
                             n, held_data, held_idx, 8'(8'h41 + n), n);
                end
                n++;
            end else if (prev_valid) begin
                total++;
                if (if_a.char_valid !== 1'b1 || if_a.char_data !== held_data ||
                    if_a.char_index !== held_idx) begin
                    bad++;
                    $display("FAIL t2_hold: valid=%b data=%h idx=%0d, want 1 %h %0d",
                             if_a.char_valid, if_a.char_data, if_a.char_index, held_data, held_idx);
                end
            end
            if (done_a) done_seen = 1'b1;
            prev_valid = if_a.char_valid;
            held_data  = if_a.char_data;
            held_idx   = if_a.char_index;
            if_a.char_ready = 1'($urandom_range(0, 1));
            prev_ready = if_a.char_ready;
        end
        if_a.char_ready = 1'b1;
        total++;
        if (done_seen !== 1'b1 || n !== 108) begin
            bad++;
            $display("FAIL t2_end: done_seen=%b bytes=%0d, want 1 108", done_seen, n);
        end
        tick;
    endtask

    // T4: abort in PRESENT at idx 40, with ready high
    task automatic test_abort;
        logic found, any_act;
        if_a.char_ready = 1'b1;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        found = 1'b0;
        for (int cyc = 1; cyc <= 400 && !found; cyc++) begin
            tick;
            if (if_a.char_valid && if_a.char_index == 8'd40) found = 1'b1;
        end
        total++;
        if (found !== 1'b1) begin
            bad++;
            $display("FAIL t4_reach40: found=%b, want 1", found);
        end
        abort_a = 1'b1;
        tick;
        abort_a = 1'b0;
        total++;
        if (busy_a !== 1'b0 || if_a.char_valid !== 1'b0 || addr_a !== 12'd1500 ||
            done_a !== 1'b0 || if_a.char_index !== 8'd0 || if_a.char_data !== 8'h00) begin
            bad++;
            $display("FAIL t4_abort: busy=%b valid=%b addr=%0d done=%b idx=%0d data=%h, want 0 0 1500 0 0 00",
                     busy_a, if_a.char_valid, addr_a, done_a, if_a.char_index, if_a.char_data);
        end
        any_act = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (done_a || busy_a) any_act = 1'b1;
        end
        total++;
        if (any_act !== 1'b0) begin
            bad++;
            $display("FAIL t4_quiet: activity after abort=%b, want 0", any_act);
        end
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        tick;
        tick;
        total++;
        if (if_a.char_valid !== 1'b1 || if_a.char_data !== 8'h41 || if_a.char_index !== 8'd0) begin
            bad++;
            $display("FAIL t4_restart: valid=%b data=%h idx=%0d, want 1 41 0",
                     if_a.char_valid, if_a.char_data, if_a.char_index);
        end
        abort_a = 1'b1;
        tick;
        abort_a = 1'b0;
    endtask

    // T5: reset while in WAIT after several bytes
    task automatic test_reset_mid;
        logic found;
        if_a.char_ready = 1'b1;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        found = 1'b0;
        for (int cyc = 1; cyc <= 100 && !found; cyc++) begin
            tick;
            if (if_a.char_valid && if_a.char_index == 8'd10) found = 1'b1;
        end
        tick;
        tick;
        total++;
        if (found !== 1'b1 || if_a.char_valid !== 1'b0 || busy_a !== 1'b1 || addr_a !== 12'd1511) begin
            bad++;
            $display("FAIL t5_pre: found=%b valid=%b busy=%b addr=%0d, want 1 0 1 1511",
                     found, if_a.char_valid, busy_a, addr_a);
        end
        reset = 1'b1;
        tick;
        total++;
        if (addr_a !== 12'd1500 || if_a.char_data !== 8'h00 || if_a.char_valid !== 1'b0 ||
            if_a.char_index !== 8'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            bad++;
            $display("FAIL t5_reset: addr=%0d data=%h valid=%b idx=%0d busy=%b done=%b, want 1500 00 0 0 0 0",
                     addr_a, if_a.char_data, if_a.char_valid, if_a.char_index, busy_a, done_a);
        end
        reset = 1'b0;
        tick;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        tick;
        tick;
        total++;
        if (if_a.char_valid !== 1'b1 || if_a.char_data !== 8'h41 || if_a.char_index !== 8'd0) begin
            bad++;
            $display("FAIL t5_restart: valid=%b data=%h idx=%0d, want 1 41 0",
                     if_a.char_valid, if_a.char_data, if_a.char_index);
        end
        abort_a = 1'b1;
        tick;
        abort_a = 1'b0;
    endtask

    // T3: NUL terminator at index 5
    task automatic test_nul;
        int n, done_cnt, done_cyc;
        init_mem();
        mem[1505] = 32'hFFFF_FF00;
        if_b.char_ready = 1'b1;
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        n = 0; done_cnt = 0; done_cyc = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick;
            if (if_b.char_valid) begin
                total++;
                if (if_b.char_data === 8'h00 || if_b.char_data !== 8'(8'h41 + n) ||
                    if_b.char_index !== 8'(n)) begin
                    bad++;
                    $display("FAIL t3_byte n=%0d: data=%h idx=%0d, want data=%h idx=%0d",
                             n, if_b.char_data, if_b.char_index, 8'(8'h41 + n), n);
                end
                n++;
            end
            if (done_b) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        total++;
        if (n !== 5 || done_cnt !== 1 || done_cyc !== 17 || busy_b !== 1'b0) begin
            bad++;
            $display("FAIL t3_end: bytes=%0d dones=%0d done_cyc=%0d busy=%b, want 5 1 17 0",
                     n, done_cnt, done_cyc, busy_b);
        end
        init_mem();
    endtask

    // T6: 3-cycle RAM, single byte
    task automatic test_lat3;
        mem[1500] = 32'h5555_557A;
        if_c.char_ready = 1'b1;
        start_c = 1'b1;
        tick;
        start_c = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick;
            if (cyc <= 3) begin
                total++;
                if (addr_c !== 12'd1500 || if_c.char_valid !== 1'b0 || busy_c !== 1'b1) begin
                    bad++;
                    $display("FAIL t6_wait cyc=%0d: addr=%0d valid=%b busy=%b, want 1500 0 1",
                             cyc, addr_c, if_c.char_valid, busy_c);
                end
            end
            if (cyc == 4) begin
                total++;
                if (if_c.char_valid !== 1'b1 || if_c.char_data !== 8'h7A || if_c.char_index !== 8'd0) begin
                    bad++;
                    $display("FAIL t6_valid: valid=%b data=%h idx=%0d, want 1 7a 0",
                             if_c.char_valid, if_c.char_data, if_c.char_index);
                end
            end
            if (cyc == 5) begin
                total++;
                if (done_c !== 1'b1 || if_c.char_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL t6_done: done=%b valid=%b, want 1 0", done_c, if_c.char_valid);
                end
            end
            if (cyc == 6) begin
                total++;
                if (done_c !== 1'b0 || busy_c !== 1'b0) begin
                    bad++;
                    $display("FAIL t6_idle: done=%b busy=%b, want 0 0", done_c, busy_c);
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; if_a.char_ready = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; if_b.char_ready = 1'b0;
        start_c = 1'b0; abort_c = 1'b0; if_c.char_ready = 1'b0;
        init_mem();
        test_reset();
        test_stream();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_nul();
        test_lat3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
